// File: rtl/nibble_add_arbiter.sv
// rtl/nibble_add_arbiter.sv - round-robin arbiter sharing one registered adder among NUM_REQ requesters
module nibble_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_sum,
  output logic                        rsp_carry,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic                        busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [ID_W-1:0]     gnt_q, gnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_sum_q, rsp_sum_d;
  logic                rsp_carry_q, rsp_carry_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

  logic                any_valid;
  logic [ID_W-1:0]     grant_idx;
  int                  scan_idx;

  // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!any_valid && req_valid[scan_idx]) begin
        any_valid = 1'b1;
        grant_idx = ID_W'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = COMPUTE;
      COMPUTE: state_d = RESPOND;
      RESPOND: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = gnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          a_d   = req_a[int'(grant_idx)*DATA_W +: DATA_W];
          b_d   = req_b[int'(grant_idx)*DATA_W +: DATA_W];
          gnt_d = grant_idx;
        end
      end
      COMPUTE: begin
        {rsp_carry_d, rsp_sum_d} = {1'b0, a_q} + {1'b0, b_q};
        rsp_id_d    = gnt_q;
        rsp_valid_d = 1'b1;
      end
      RESPOND: begin
        // Result fields stay sticky after the handshake; only valid drops.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ-1)) ? '0 : rsp_id_q + ID_W'(1);
        end
      end
      default: ;
    endcase
  end

  // rst_n gating keeps req_ready low during reset even though it is combinational.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && any_valid) req_ready[grant_idx] = 1'b1;
    busy = (state_q != IDLE);
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_nibble_add_arbiter.sv
// tb/tb_nibble_add_arbiter.sv - directed table-driven bench for nibble_add_arbiter
module tb_nibble_add_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_sum;
  logic        rsp_carry;
  logic [1:0]  rsp_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  nibble_add_arbiter #(.NUM_REQ(4), .DATA_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  id;
    logic [3:0]  sum;
    logic        carry;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Entered at a falling edge with the DUT idle; returns at a falling edge idle again.
  task automatic run_txn(input logic [3:0] rv, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] id, input logic [3:0] sum, input logic carry);
    req_valid = rv;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'b1;
    #1;
    chk("grant", {28'd0, req_ready}, 32'd1 << id);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("compute_ready", {28'd0, req_ready}, 32'd0);
    chk("compute_busy", {31'd0, busy}, 32'd1);
    chk("compute_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_sum", {28'd0, rsp_sum}, {28'd0, sum});
    chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, carry});
    chk("rsp_id", {30'd0, rsp_id}, {30'd0, id});
    @(negedge clk);
    #1;
    chk("post_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("sticky_sum", {28'd0, rsp_sum}, {28'd0, sum});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    int cyc;
    int last;
    int waited;

    // Grant expectations follow rr_ptr as it evolves from 0 through the table.
    vecs[0] = '{4'b0001, 16'hFFF7, 16'hFFF9, 2'd0, 4'h0, 1'b1};
    vecs[1] = '{4'b0010, 16'h5E3A, 16'h124B, 2'd1, 4'h7, 1'b0};
    vecs[2] = '{4'b1001, 16'hF001, 16'h1001, 2'd3, 4'h0, 1'b1};
    vecs[3] = '{4'b0101, 16'h0805, 16'h0805, 2'd0, 4'hA, 1'b0};
    vecs[4] = '{4'b0101, 16'h0805, 16'h0805, 2'd2, 4'h0, 1'b1};
    vecs[5] = '{4'b0011, 16'h002F, 16'h0060, 2'd0, 4'hF, 1'b0};
    vecs[6] = '{4'b1110, 16'h7700, 16'h7700, 2'd1, 4'h0, 1'b0};
    vecs[7] = '{4'b1000, 16'h9000, 16'h6000, 2'd3, 4'hF, 1'b0};

    rst_n     = 1'b1;
    req_valid = 4'b0000;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    rsp_ready = 1'b0;
    #2;
    rst_n     = 1'b0;
    req_valid = 4'($urandom_range(1, 15));
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    rsp_ready = 1'($urandom);
    #1;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_sum", {28'd0, rsp_sum}, 32'd0);
    chk("rst_carry", {31'd0, rsp_carry}, 32'd0);
    chk("rst_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0000;

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].rv, vecs[i].a, vecs[i].b, vecs[i].id, vecs[i].sum, vecs[i].carry);

    // All four requesting: rotation 0,1,2,3,0 with a grant every third cycle.
    exp_order = '{0, 1, 2, 3, 0};
    req_valid = 4'b1111;
    req_a     = 16'h4321;
    req_b     = 16'h1111;
    rsp_ready = 1'b1;
    cyc  = 0;
    last = 0;
    #1;
    for (int k = 0; k < 5; k++) begin
      waited = 0;
      while (req_ready == 4'b0000 && waited < 8) begin
        @(negedge clk);
        #1;
        waited++;
        cyc++;
      end
      chk("rr_grant", {28'd0, req_ready}, 32'd1 << exp_order[k]);
      if (k > 0) chk("rr_gap", 32'(cyc - last), 32'd3);
      last = cyc;
      @(negedge clk);
      #1;
      cyc++;
    end
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    chk("rr_last_id", {30'd0, rsp_id}, 32'd0);
    chk("rr_last_sum", {28'd0, rsp_sum}, 32'd2);
    @(negedge clk);

    // Stall: rr_ptr=1, requester 2 alone is granted; others arrive mid-stall.
    req_valid = 4'b0100;
    req_a     = 16'h0300;
    req_b     = 16'h0400;
    rsp_ready = 1'b0;
    #1;
    chk("stall_grant", {28'd0, req_ready}, 32'b0100);
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("stall_comp_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_sum", {28'd0, rsp_sum}, 32'd7);
      chk("stall_carry", {31'd0, rsp_carry}, 32'd0);
      chk("stall_id", {30'd0, rsp_id}, 32'd2);
      chk("stall_ready", {28'd0, req_ready}, 32'd0);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("stall_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("stall_next_grant", {28'd0, req_ready}, 32'b1000);
    req_valid = 4'b0000;
    @(negedge clk);

    // Reset while responding: rr_ptr=3, requester 0 is the only one asking.
    req_valid = 4'b0001;
    req_a     = 16'h0001;
    req_b     = 16'h0002;
    rsp_ready = 1'b0;
    #1;
    chk("rr_wrap_grant", {28'd0, req_ready}, 32'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    chk("pre_rst_sum", {28'd0, rsp_sum}, 32'd3);
    #1;
    req_valid = 4'b1111;
    rst_n     = 1'b0;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_sum", {28'd0, rsp_sum}, 32'd0);
    chk("arst_id", {30'd0, rsp_id}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(4'b1111, 16'hFFFF, 16'hFFFF, 2'd0, 4'hE, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
